// File: rtl/cache_ctrl.sv
// Miss-handling controller between the CPU port, a write-back data cache and main memory.
// Optional hit/miss/write-back counters are built when CACHE_CTRL_STATS_EN is defined.
module cache_ctrl #(
  parameter int unsigned ADDR_W  = 30,
  parameter int unsigned INDEX_W = 10,
  parameter int unsigned DATA_W  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cpu_rd,
  input  logic                       cpu_wr,
  input  logic [ADDR_W-1:0]          cpu_addr,
  input  logic [DATA_W-1:0]          cpu_wdata,
  output logic                       cpu_ready,
  output logic [DATA_W-1:0]          cpu_rdata,
  output logic [ADDR_W-1:0]          cache_addr,
  output logic                       cache_rd,
  output logic                       cache_wr,
  output logic [DATA_W-1:0]          cache_wdata,
  output logic                       cache_substitude,
  output logic [DATA_W-1:0]          cache_substitude_data,
  input  logic                       cache_r_hit,
  input  logic                       cache_r_miss,
  input  logic [DATA_W-1:0]          cache_data,
  input  logic                       cache_dirty_bit,
  input  logic [DATA_W-1:0]          cache_wb_data,
  input  logic [ADDR_W-INDEX_W-1:0]  cache_wb_tag,
  input  logic                       cache_substitude_fin,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic [DATA_W-1:0]          mem_rdata,
  input  logic                       mem_ack
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [31:0]                stat_hit,
  output logic [31:0]                stat_miss,
  output logic [31:0]                stat_wb
`endif
);

  localparam int unsigned TAG_W = ADDR_W - INDEX_W;

  typedef enum logic [3:0] {
    IDLE, LOOKUP, WRITE, VICTIM, WB, REFILL, FILL, FILL_WAIT, DONE
  } state_t;

  state_t state;
  logic   write_q;
  logic   replay_q;

  // cache_addr / cache_wdata double as the latched request address and store data
  always_ff @(posedge clk) begin
    if (rst) begin
      state                 <= IDLE;
      write_q               <= 1'b0;
      replay_q              <= 1'b0;
      cpu_ready             <= 1'b0;
      cpu_rdata             <= '0;
      cache_addr            <= '0;
      cache_rd              <= 1'b0;
      cache_wr              <= 1'b0;
      cache_wdata           <= '0;
      cache_substitude      <= 1'b0;
      cache_substitude_data <= '0;
      mem_req               <= 1'b0;
      mem_we                <= 1'b0;
      mem_addr              <= '0;
      mem_wdata             <= '0;
`ifdef CACHE_CTRL_STATS_EN
      stat_hit              <= '0;
      stat_miss             <= '0;
      stat_wb               <= '0;
`endif
    end else begin
      cpu_ready        <= 1'b0;
      cache_wr         <= 1'b0;
      cache_substitude <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_wr || cpu_rd) begin
            cache_addr  <= cpu_addr;
            cache_wdata <= cpu_wdata;
            write_q     <= cpu_wr;
            replay_q    <= 1'b0;
            cache_rd    <= 1'b1;
            state       <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (cache_r_hit) begin
            cache_rd <= 1'b0;
`ifdef CACHE_CTRL_STATS_EN
            if (!replay_q && stat_hit != 32'hFFFF_FFFF) stat_hit <= stat_hit + 32'd1;
`endif
            if (write_q) begin
              cache_wr <= 1'b1;
              state    <= WRITE;
            end else begin
              cpu_rdata <= cache_data;
              cpu_ready <= 1'b1;
              state     <= DONE;
            end
          end else if (cache_r_miss) begin
            cache_rd <= 1'b0;
            replay_q <= 1'b1;
`ifdef CACHE_CTRL_STATS_EN
            if (stat_miss != 32'hFFFF_FFFF) stat_miss <= stat_miss + 32'd1;
`endif
            state    <= VICTIM;
          end
        end
        WRITE: begin
          cpu_ready <= 1'b1;
          state     <= DONE;
        end
        // victim info is now registered against our index
        VICTIM: begin
          mem_req   <= 1'b1;
          mem_wdata <= cache_wb_data;
          if (cache_dirty_bit) begin
            mem_we   <= 1'b1;
            mem_addr <= {TAG_W'(cache_wb_tag), cache_addr[INDEX_W-1:0]};
            state    <= WB;
          end else begin
            mem_we   <= 1'b0;
            mem_addr <= cache_addr;
            state    <= REFILL;
          end
        end
        WB: begin
          if (mem_ack) begin
            mem_we   <= 1'b0;
            mem_addr <= cache_addr;
`ifdef CACHE_CTRL_STATS_EN
            if (stat_wb != 32'hFFFF_FFFF) stat_wb <= stat_wb + 32'd1;
`endif
            state    <= REFILL;
          end
        end
        REFILL: begin
          if (mem_ack) begin
            mem_req               <= 1'b0;
            mem_we                <= 1'b0;
            cache_substitude      <= 1'b1;
            cache_substitude_data <= mem_rdata;
            state                 <= FILL;
          end
        end
        FILL: state <= FILL_WAIT;
        FILL_WAIT: begin
          if (cache_substitude_fin) begin
            cache_rd <= 1'b1;
            state    <= LOOKUP;
          end
        end
        DONE: begin
          cpu_rdata <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
- Miss-handling controller between the CPU load/store port, the 4-way write-back data cache and main memory.
- Probes the cache for every CPU access. On a hit it completes the access.
- On a miss it writes back a dirty victim, fetches the missing word, installs it in the cache with a one-cycle `substitude` pulse, then replays the lookup.
- Write-allocate. One outstanding CPU request.

Parameters:
- ADDR_W, 30, word address width (tag + index).
- INDEX_W, 10, set index width; TAG_W = ADDR_W-INDEX_W (derived, 20).
- DATA_W, 32, data word width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cpu_rd  in  1  read request (sampled in IDLE)
- cpu_wr  in  1  write request (sampled in IDLE; priority over cpu_rd)
- cpu_addr  in  ADDR_W  request word address
- cpu_wdata  in  DATA_W  store data
- cpu_ready  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  load data, valid while cpu_ready=1
- cache_addr  out  ADDR_W  address to cache, held stable for whole transaction
- cache_rd  out  1  cache probe
- cache_wr  out  1  cache write
- cache_wdata  out  DATA_W  cache write data
- cache_substitude  out  1  fill request (one-cycle pulse)
- cache_substitude_data  out  DATA_W  fill data
- cache_r_hit  in  1  combinational read hit
- cache_r_miss  in  1  combinational read miss
- cache_data  in  DATA_W  hit data
- cache_dirty_bit  in  1  victim dirty flag (registered in cache from previous-cycle address)
- cache_wb_data  in  DATA_W  victim data (registered)
- cache_wb_tag  in  TAG_W  victim tag (registered, same timing as wb_data)
- cache_substitude_fin  in  1  fill done
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  memory word address
- mem_wdata  out  DATA_W  write-back data
- mem_rdata  in  DATA_W  read data, valid with mem_ack
- mem_ack  in  1  one-cycle completion from memory

Behaviour:
- Reset: state IDLE. All outputs 0: cpu_ready, cpu_rdata, cache_*, mem_*. Latched addr/data/op cleared. Reset mid-transaction abandons it: mem_req drops the next cycle and no cache write/fill is issued.
- IDLE:
  - If cpu_wr|cpu_rd, latch addr, wdata and op (write if cpu_wr), then go to LOOKUP.
  - Requests arriving in any other state are ignored; CPU must hold until cpu_ready.
- LOOKUP: cache_addr=latched addr, cache_rd=1, cache_wr=0.
  - r_hit & read: latch cache_data into cpu_rdata, go to DONE.
  - r_hit & write: go to WRITE.
  - r_miss: go to VICTIM.
- WRITE: cache_wr=1, cache_wdata=latched wdata, cache_rd=0, for exactly one cycle, then DONE.
- VICTIM: one wait cycle so the registered cache_dirty_bit/wb_data/wb_tag reflect the latched index.
  - At end of cycle latch wb_data and {wb_tag,index}.
  - dirty=1: go to WB. Otherwise go to REFILL.
- WB: mem_req=1, mem_we=1, mem_addr={wb_tag,index}, mem_wdata=latched victim. On mem_ack go to REFILL.
- REFILL: mem_req=1, mem_we=0, mem_addr=latched addr. On mem_ack latch mem_rdata and go to FILL.
- FILL: cache_substitude=1 for exactly one cycle, cache_substitude_data=fill word, then FILL_WAIT.
- FILL_WAIT: wait for cache_substitude_fin=1, then LOOKUP (replay; the replay hits).
- DONE: cpu_ready=1 for one cycle, cpu_rdata valid, then IDLE. cpu_rdata returns to 0 after DONE. A new request is accepted in the following IDLE cycle.
- Latency (request sampled at cycle T):
  - read hit: cpu_ready at T+2.
  - write hit: cpu_ready at T+3.
  - clean miss with refill ack at cycle A: cpu_ready at A+4.
- Output hygiene:
  - mem_req stays asserted continuously across WB→REFILL only as separate requests: it is low for zero cycles between them, but mem_we/mem_addr change on the transition cycle.
  - cache_rd and cache_wr are never both 1.
  - cache_substitude is never asserted while cache_wr=1.
- mem_ack outside WB/REFILL is ignored.

Optional Feature:
- Macro CACHE_CTRL_STATS_EN.
- Defined: adds outputs stat_hit, stat_miss, stat_wb (each 32 bit) with these rules:
  - stat_hit increments on the first LOOKUP hit of a transaction (replays are not counted).
  - stat_miss increments on entering VICTIM.
  - stat_wb increments on WB mem_ack.
  - All counters saturate at 32'hFFFFFFFF and clear on rst.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Preload cache hit at addr 30'h00001005 with data 32'hDEADBEEF; cpu_rd at T -> cpu_ready=1 and cpu_rdata=32'hDEADBEEF at T+2, no mem_req.
- Write hit at 30'h00001005 with cpu_wdata=32'h12345678 -> cache_wr pulse at T+2 with cache_wdata=32'h12345678, cpu_ready at T+3, mem_req never set.
- Clean read miss at 30'h00002007, memory returns 32'hCAFEF00D with 3-cycle ack delay -> single read mem_req with mem_addr=30'h00002007; one cache_substitude cycle with data 32'hCAFEF00D; replay hits; cpu_rdata=32'hCAFEF00D.
- Dirty miss: victim tag 20'h00001, index 10'h007, data 32'hAAAA5555 -> first mem write to addr 30'h00000407 with data 32'hAAAA5555, then read of the new address, then fill, then cpu_ready.
- Assert rst during REFILL with mem_req=1 -> next cycle mem_req=0, state IDLE, cpu_ready=0, no cache_substitude; a later ack is ignored.
- cpu_rd=cpu_wr=1 simultaneously on a hit -> treated as a write (cache_wr pulse, cpu_rdata=0). With CACHE_CTRL_STATS_EN, after scenarios 1–4 stat_hit=2, stat_miss=2, stat_wb=1.
